// File: rtl/bids22_settle.sv
// Settle stage for the bids22 auction core: keeps the X/Y/Z credit ledger and
// logs one result record per round into a first-word-fall-through FIFO.
module bids22_settle #(
   parameter int DEPTH = 4,
   parameter int RID_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ld_valid,
   input  logic [1:0]         ld_sel,
   input  logic [31:0]        ld_data,
   input  logic [31:0]        bid_cost,
   input  logic               X_ack,
   input  logic               Y_ack,
   input  logic               Z_ack,
   input  logic               roundOver,
   input  logic               X_win,
   input  logic               Y_win,
   input  logic               Z_win,
   input  logic [15:0]        maxBid,
   input  logic [2:0]         err,
   output logic [31:0]        X_balance,
   output logic [31:0]        Y_balance,
   output logic [31:0]        Z_balance,
   input  logic               rd_en,
   output logic               rd_valid,
   output logic [RID_W+21:0]  rd_data,
   output logic               fifo_ovf,
   output logic               busy
);

   localparam int AW    = $clog2(DEPTH);
   localparam int REC_W = RID_W + 22;

   typedef enum logic [1:0] {IDLE, CAPTURE, SETTLE, PUSH} state_t;

   state_t            state;
   logic [2:0]        win_q;      // {Z, Y, X}
   logic [15:0]       bid_q;
   logic [2:0]        err_q;
   logic [1:0]        winner_q;
   logic [15:0]       amount_q;
   logic              uflow_q;
   logic [RID_W-1:0]  round_id;

   logic [31:0]       bal_q [3];
   logic [31:0]       bal_d [3];
   logic [32:0]       charge [3];
   logic [2:0]        acks;
   logic              uflow_d;

   assign acks      = {Z_ack, Y_ack, X_ack};
   assign X_balance = bal_q[0];
   assign Y_balance = bal_q[1];
   assign Z_balance = bal_q[2];
   assign busy      = (state != IDLE);

   // Per-lane charge: fee for an ack, plus the winning amount during SETTLE.
   // A load to the lane overrides whatever charge would have landed.
   always_comb begin
      // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
      uflow_d = 1'b0;
      for (int i = 0; i < 3; i++) begin
         charge[i] = acks[i] ? {1'b0, bid_cost} : 33'd0;
         if (state == SETTLE && winner_q == 2'(i + 1)) begin
            charge[i] = charge[i] + {17'd0, bid_q};
            uflow_d   = ({1'b0, bal_q[i]} < charge[i]);
         end
         bal_d[i] = ({1'b0, bal_q[i]} < charge[i]) ? 32'd0 : bal_q[i] - charge[i][31:0];
         if (ld_valid && ld_sel == 2'(i + 1))
            bal_d[i] = ld_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 3; i++) bal_q[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++) bal_q[i] <= bal_d[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         win_q    <= '0;
         bid_q    <= '0;
         err_q    <= '0;
         winner_q <= '0;
         amount_q <= '0;
         uflow_q  <= 1'b0;
         round_id <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (roundOver) begin
                  win_q <= {Z_win, Y_win, X_win};
                  bid_q <= maxBid;
                  err_q <= err;
                  state <= CAPTURE;
               end
            end
            CAPTURE: begin
               case (win_q)
                  3'b001:  winner_q <= 2'd1;
                  3'b010:  winner_q <= 2'd2;
                  3'b100:  winner_q <= 2'd3;
                  default: winner_q <= 2'd0;
               endcase
               amount_q <= (win_q == 3'b001 || win_q == 3'b010 || win_q == 3'b100) ? bid_q : 16'd0;
               uflow_q  <= 1'b0;
               state    <= SETTLE;
            end
            SETTLE: begin
               uflow_q <= uflow_d;
               state   <= PUSH;
            end
            PUSH: begin
               round_id <= round_id + 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Result FIFO
   logic [REC_W-1:0]  mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [AW:0]       count;
   logic              push, pop, full, do_push;
   logic [REC_W-1:0]  record;

   assign record  = {round_id, winner_q, err_q, uflow_q, amount_q};
   assign push    = (state == PUSH);
   assign pop     = rd_en && (count != '0);
   assign full    = (count == (AW + 1)'(DEPTH));
   assign do_push = push && (!full || pop);

   assign rd_valid = (count != '0);
   assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

   // NOTE: storage is not reset; rd_data is masked while empty so stale entries never show.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= record;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         fifo_ovf <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push && !do_push) fifo_ovf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_bids22_settle.sv
// Directed bench for bids22_settle: ledger charging, settle records, FIFO
// overflow/ordering and mid-settle reset, with hand-computed expectations.
module tb_bids22_settle;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ld_valid = 1'b0;
   logic [1:0]  ld_sel = '0;
   logic [31:0] ld_data = '0;
   logic [31:0] bid_cost = '0;
   logic        X_ack = 1'b0, Y_ack = 1'b0, Z_ack = 1'b0;
   logic        roundOver = 1'b0;
   logic        X_win = 1'b0, Y_win = 1'b0, Z_win = 1'b0;
   logic [15:0] maxBid = '0;
   logic [2:0]  err = '0;
   logic [31:0] X_balance, Y_balance, Z_balance;
   logic        rd_en = 1'b0;
   logic        rd_valid;
   logic [29:0] rd_data;
   logic        fifo_ovf;
   logic        busy;

   int vectors = 0;
   int miscompares = 0;

   bids22_settle #(.DEPTH(4), .RID_W(8)) dut (
      .clk(clk), .reset(reset),
      .ld_valid(ld_valid), .ld_sel(ld_sel), .ld_data(ld_data), .bid_cost(bid_cost),
      .X_ack(X_ack), .Y_ack(Y_ack), .Z_ack(Z_ack),
      .roundOver(roundOver), .X_win(X_win), .Y_win(Y_win), .Z_win(Z_win),
      .maxBid(maxBid), .err(err),
      .X_balance(X_balance), .Y_balance(Y_balance), .Z_balance(Z_balance),
      .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data),
      .fifo_ovf(fifo_ovf), .busy(busy)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled just after the falling edge.
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [29:0] rec(input logic [7:0] id, input logic [1:0] w,
                                       input logic [2:0] e, input logic u, input logic [15:0] a);
      return {id, w, e, u, a};
   endfunction

   task automatic load(input logic [1:0] sel, input logic [31:0] data);
      ld_valid = 1'b1; ld_sel = sel; ld_data = data;
      tick(1);
      ld_valid = 1'b0; ld_sel = '0;
   endtask

   task automatic start_round(input logic [2:0] zyx, input logic [15:0] bid, input logic [2:0] e);
      roundOver = 1'b1; {Z_win, Y_win, X_win} = zyx; maxBid = bid; err = e;
      tick(1);
      roundOver = 1'b0; {Z_win, Y_win, X_win} = 3'b000;
   endtask

   task automatic run_round(input logic [2:0] zyx, input logic [15:0] bid, input logic [2:0] e);
      start_round(zyx, bid, e);
      tick(3);
   endtask

   task automatic pop1;
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
   endtask

   initial begin
      tick(2);
      check("rst_x", X_balance, 0);
      check("rst_valid", {31'd0, rd_valid}, 0);
      check("rst_data", {2'd0, rd_data}, 0);
      check("rst_ovf", {31'd0, fifo_ovf}, 0);
      check("rst_busy", {31'd0, busy}, 0);
      reset = 1'b0;

      // Ack charging
      load(2'd1, 100); load(2'd2, 50); load(2'd3, 20);
      bid_cost = 2; X_ack = 1'b1; Z_ack = 1'b1;
      tick(1);
      X_ack = 1'b0; Z_ack = 1'b0;
      check("ack_x", X_balance, 98);
      check("ack_y", Y_balance, 50);
      check("ack_z", Z_balance, 18);

      // Y wins 30
      start_round(3'b010, 30, 3'd0);
      check("busy_capture", {31'd0, busy}, 1);
      tick(3);
      check("ywin_y", Y_balance, 20);
      check("ywin_valid", {31'd0, rd_valid}, 1);
      check("ywin_rec", {2'd0, rd_data}, {2'd0, rec(0, 2, 0, 0, 30)});
      check("ywin_busy", {31'd0, busy}, 0);
      pop1;
      check("ywin_popped", {31'd0, rd_valid}, 0);

      // Z underflows
      run_round(3'b100, 25, 3'd0);
      check("zuf_z", Z_balance, 0);
      check("zuf_rec", {2'd0, rd_data}, {2'd0, rec(1, 3, 0, 1, 25)});
      pop1;

      // Two winners: no charge, amount 0
      run_round(3'b011, 77, 3'b101);
      check("multi_x", X_balance, 98);
      check("multi_y", Y_balance, 20);
      check("multi_rec", {2'd0, rd_data}, {2'd0, rec(2, 0, 5, 0, 0)});

      // FIFO fill / overflow / ordering from a clean reset
      reset = 1'b1; tick(1); reset = 1'b0;
      check("rst2_valid", {31'd0, rd_valid}, 0);
      for (int i = 0; i < 4; i++) run_round(3'b000, 9, 3'd0);
      check("full_ovf", {31'd0, fifo_ovf}, 0);
      check("full_head", {2'd0, rd_data}, {2'd0, rec(0, 0, 0, 0, 0)});
      // Round 4 pushes while the head is popped on the same edge
      start_round(3'b000, 9, 3'd0);
      tick(2);
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
      check("pushpop_ovf", {31'd0, fifo_ovf}, 0);
      check("pushpop_head", {2'd0, rd_data}, {2'd0, rec(1, 0, 0, 0, 0)});
      // Round 5 is dropped
      run_round(3'b000, 9, 3'd0);
      check("drop_ovf", {31'd0, fifo_ovf}, 1);
      for (int i = 1; i <= 4; i++) begin
         check($sformatf("drain_%0d", i), {2'd0, rd_data}, {2'd0, rec(8'(i), 0, 0, 0, 0)});
         pop1;
      end
      check("drained_valid", {31'd0, rd_valid}, 0);
      check("drained_data", {2'd0, rd_data}, 0);
      pop1;
      check("empty_pop_valid", {31'd0, rd_valid}, 0);
      run_round(3'b000, 9, 3'd3);
      check("after_empty_pop", {2'd0, rd_data}, {2'd0, rec(6, 0, 3, 0, 0)});
      check("ovf_sticky", {31'd0, fifo_ovf}, 1);

      // Reset while in SETTLE
      load(2'd1, 10);
      start_round(3'b001, 5, 3'd0);
      tick(1);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check("rstset_x", X_balance, 0);
      check("rstset_busy", {31'd0, busy}, 0);
      check("rstset_valid", {31'd0, rd_valid}, 0);
      check("rstset_ovf", {31'd0, fifo_ovf}, 0);
      tick(3);
      check("rstset_nopush", {31'd0, rd_valid}, 0);

      // Load beats ack on the same lane only
      load(2'd2, 10);
      ld_valid = 1'b1; ld_sel = 2'd1; ld_data = 40; X_ack = 1'b1; Y_ack = 1'b1;
      tick(1);
      ld_valid = 1'b0; ld_sel = '0; X_ack = 1'b0; Y_ack = 1'b0;
      check("ldack_x", X_balance, 40);
      check("ldack_y", Y_balance, 8);
      load(2'd3, 1);
      Z_ack = 1'b1; tick(1); Z_ack = 1'b0;
      check("ack_sat_z", Z_balance, 0);

      // Ack landing in the SETTLE cycle adds to the winning charge
      start_round(3'b001, 30, 3'd0);
      tick(1);
      X_ack = 1'b1; tick(1); X_ack = 1'b0;
      tick(1);
      check("setack_x", X_balance, 8);
      check("setack_rec", {2'd0, rd_data}, {2'd0, rec(0, 1, 0, 0, 30)});
      pop1;
      start_round(3'b001, 7, 3'd0);
      tick(1);
      X_ack = 1'b1; tick(1); X_ack = 1'b0;
      tick(1);
      check("setack_uf_x", X_balance, 0);
      check("setack_uf_rec", {2'd0, rd_data}, {2'd0, rec(1, 1, 0, 1, 7)});

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
